// File: rtl/serial_frame_deser_pkg.sv
// Shared types and defaults for the serial frame deserializer.
// Holds the FSM state enum, the buffered byte record (frame markers plus
// payload) and the default sync pattern searched for in the bit stream.
package serial_frame_deser_pkg;

  localparam int DEF_DW = 8;
  localparam logic [DEF_DW-1:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  // One buffered byte: start/end-of-frame markers travel with the payload
  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [DEF_DW-1:0] data;
  } frame_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the deserializer's output buffer.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   push, push_data       - write request and word
//   pop                   - read request (ignored when empty)
//   pop_data              - head word, forced to 0 while empty
//   full, empty           - occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: hunts for a bit-aligned sync word in the
// incoming serial stream, then assembles FRAME_LEN MSB-first bytes and
// queues them, tagged with start/end-of-frame, in a small output FIFO.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   din, din_en                - serial bit and its qualifier
//   byte_data/sof/eof, valid   - head of the output FIFO
//   byte_ready                 - consumer takes the head byte
//   locked                     - currently assembling a frame
//   overflow                   - sticky: a completed byte was dropped
module serial_frame_deser
  import serial_frame_deser_pkg::*;
#(
  parameter int          DW         = DEF_DW,
  parameter logic [DW-1:0] SYNC     = SYNC_DEFAULT,
  parameter int          FRAME_LEN  = 4,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_en,
  output logic [DW-1:0] byte_data,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          byte_sof,
  output logic          byte_eof,
  output logic          locked,
  output logic          overflow
);

  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DW - 1);
  localparam logic [7:0]     BYTE_LAST = 8'(FRAME_LEN - 1);

  state_t          state;
  state_t          nextState;
  logic [DW-1:0]   huntReg;
  logic [DW-1:0]   asmReg;
  logic [DW-1:0]   huntNext;
  logic [DW-1:0]   asmNext;
  logic [BCW-1:0]  bitCnt;
  logic [7:0]      byteCnt;
  logic            push;
  logic            lastByte;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [DW+1:0]   headWord;

  assign huntNext = {huntReg[DW-2:0], din};
  assign asmNext  = {asmReg[DW-2:0], din};
  assign lastByte = (byteCnt == BYTE_LAST);

  // Next state and byte-complete strobe; sync is checked on every bit
  always_comb begin
    nextState = state;
    push      = 1'b0;
    case (state)
      HUNT: begin
        if (din_en && huntNext == SYNC) nextState = DATA;
      end
      DATA: begin
        if (din_en && bitCnt == BIT_LAST) begin
          push = 1'b1;
          if (lastByte) nextState = HUNT;
        end
      end
      default: nextState = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= nextState;
  end

  // Shift registers and counters; counters sit at zero while hunting so a
  // new frame always starts from byte 0, bit 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      huntReg <= '0;
      asmReg  <= '0;
      bitCnt  <= '0;
      byteCnt <= '0;
    end else if (din_en) begin
      if (state == HUNT) begin
        huntReg <= huntNext;
        bitCnt  <= '0;
        byteCnt <= '0;
      end else begin
        asmReg <= asmNext;
        if (push) begin
          bitCnt <= '0;
          if (lastByte) begin
            byteCnt <= '0;
            huntReg <= '0;
          end else begin
            byteCnt <= byteCnt + 1'b1;
          end
        end else begin
          bitCnt <= bitCnt + 1'b1;
        end
      end
    end
  end

  // A byte completing while the FIFO is full and not draining is lost
  always_ff @(posedge clk) begin
    if (!rst_n) overflow <= 1'b0;
    else if (push && fifoFull && !(byte_valid && byte_ready)) overflow <= 1'b1;
  end

  sync_fifo #(
    .W     (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({(byteCnt == 8'd0), lastByte, asmNext}),
    .pop       (byte_ready),
    .pop_data  (headWord),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  assign byte_valid = !fifoEmpty;
  assign byte_sof   = headWord[DW+1];
  assign byte_eof   = headWord[DW];
  assign byte_data  = headWord[DW-1:0];
  assign locked     = (state == DATA);

endmodule

// File: tb/tb_serial_frame_deser.sv
// Self-checking bench for serial_frame_deser: reset table, directed frame
// sequences, then randomized traffic against a queue-based reference model.
module tb_serial_frame_deser;
  import serial_frame_deser_pkg::*;

  localparam int         DW        = 8;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         FRAME_LEN = 4;
  localparam int         DEPTH     = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_sof;
  logic       byte_eof;
  logic       locked;
  logic       overflow;

  int applied = 0;
  int miscompares = 0;

  serial_frame_deser #(
    .DW(DW), .SYNC(SYNC), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_sof(byte_sof), .byte_eof(byte_eof), .locked(locked),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: bit windows as queues, output buffer as a queue
  int           huntQ[$];
  int           byteQ[$];
  int           mByteIdx;
  bit           mLocked;
  bit           mOvf;
  frame_entry_t fifoQ[$];
  frame_entry_t gotQ[$];

  function automatic logic [31:0] bitsVal(int q[$]);
    logic [31:0] v = 0;
    foreach (q[i]) v = v * 2 + 32'(q[i]);
    return v;
  endfunction

  task automatic clearHunt();
    huntQ.delete();
    for (int i = 0; i < DW; i++) huntQ.push_back(0);
  endtask

  task automatic modelStep(input logic r, input logic d, input logic e, input logic rdy);
    bit           pop;
    bit           havePush;
    int           preSize;
    frame_entry_t ent;
    if (!r) begin
      mLocked = 0; mOvf = 0; mByteIdx = 0;
      byteQ.delete(); fifoQ.delete(); clearHunt();
      return;
    end
    pop = (fifoQ.size() > 0) && rdy;
    havePush = 0;
    ent = '0;
    if (e) begin
      if (!mLocked) begin
        huntQ.push_back(int'(d));
        void'(huntQ.pop_front());
        if (bitsVal(huntQ) == 32'(SYNC)) begin
          mLocked = 1; mByteIdx = 0; byteQ.delete();
        end
      end else begin
        byteQ.push_back(int'(d));
        if (byteQ.size() == DW) begin
          ent.data = bitsVal(byteQ);
          ent.sof  = (mByteIdx == 0);
          ent.eof  = (mByteIdx == FRAME_LEN - 1);
          havePush = 1;
          byteQ.delete();
          mByteIdx++;
          if (mByteIdx == FRAME_LEN) begin
            mLocked = 0;
            clearHunt();
          end
        end
      end
    end
    preSize = fifoQ.size();
    if (pop) void'(fifoQ.pop_front());
    if (havePush) begin
      if (preSize < DEPTH || pop) fifoQ.push_back(ent);
      else mOvf = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("model_valid", byte_valid, fifoQ.size() != 0);
    cmp("model_locked", locked, mLocked);
    cmp("model_overflow", overflow, mOvf);
    if (fifoQ.size() != 0 && byte_valid) begin
      cmp("model_data", byte_data, fifoQ[0].data);
      cmp("model_sof", byte_sof, fifoQ[0].sof);
      cmp("model_eof", byte_eof, fifoQ[0].eof);
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check
  // at the following falling edge
  task automatic applyStimulus(input logic r, input logic d, input logic e, input logic rdy);
    rst_n = r; din = d; din_en = e; byte_ready = rdy;
    if (r && byte_valid && byte_ready)
      gotQ.push_back('{sof: byte_sof, eof: byte_eof, data: byte_data});
    @(posedge clk);
    modelStep(r, d, e, rdy);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps, input logic rdy);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, b[i], 1'b1, rdy);
      if (gaps) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, rdy);
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    gotQ.delete();
  endtask

  task automatic checkGot(input string name, input logic [7:0] exp[$], input bit fullFrame);
    cmp({name, "_count"}, gotQ.size(), exp.size());
    for (int i = 0; i < exp.size() && i < gotQ.size(); i++) begin
      cmp({name, "_data"}, gotQ[i].data, exp[i]);
      cmp({name, "_sof"}, gotQ[i].sof, i == 0);
      cmp({name, "_eof"}, gotQ[i].eof, fullFrame && (i == exp.size() - 1));
    end
  endtask

  typedef struct {
    logic rstN;
    logic din;
    logic dinEn;
    logic ready;
    logic expValid;
    logic expLocked;
    logic expOverflow;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] frame[$];

  initial begin
    // Reset table: 3 reset cycles with din=1, then 16 zero bits
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].din, vecs[i].dinEn, vecs[i].ready);
      cmp("tbl_valid", byte_valid, vecs[i].expValid);
      cmp("tbl_locked", locked, vecs[i].expLocked);
      cmp("tbl_overflow", overflow, vecs[i].expOverflow);
      if (!vecs[i].rstN) begin
        cmp("tbl_rst_data", byte_data, 0);
        cmp("tbl_rst_sof", byte_sof, 0);
        cmp("tbl_rst_eof", byte_eof, 0);
      end
    end

    // Basic frame with single-cycle latency and lock timing
    doReset(1);
    sendByte(8'hA5, 0, 1'b1);
    cmp("basic_locked", locked, 1);
    sendByte(8'h11, 0, 1'b1);
    cmp("basic_lat_valid", byte_valid, 1);
    cmp("basic_lat_data", byte_data, 8'h11);
    cmp("basic_lat_sof", byte_sof, 1);
    sendByte(8'h22, 0, 1'b1);
    sendByte(8'h33, 0, 1'b1);
    sendByte(8'h44, 0, 1'b1);
    cmp("basic_unlock", locked, 0);
    cmp("basic_eof", byte_eof, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    frame = '{8'h11, 8'h22, 8'h33, 8'h44};
    checkGot("basic", frame, 1);

    // Sync preceded by stray bits, not byte aligned
    doReset(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    sendByte(8'hA5, 0, 1'b1);
    cmp("unal_locked", locked, 1);
    sendByte(8'h5A, 0, 1'b1);
    sendByte(8'h00, 0, 1'b1);
    sendByte(8'hFF, 0, 1'b1);
    sendByte(8'h81, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    frame = '{8'h5A, 8'h00, 8'hFF, 8'h81};
    checkGot("unaligned", frame, 1);

    // Enable low on every other cycle
    doReset(1);
    sendByte(8'hA5, 1, 1'b1);
    sendByte(8'h11, 1, 1'b1);
    sendByte(8'h22, 1, 1'b1);
    sendByte(8'h33, 1, 1'b1);
    sendByte(8'h44, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    frame = '{8'h11, 8'h22, 8'h33, 8'h44};
    checkGot("gaps", frame, 1);

    // Backpressure: FIFO fills, later bytes dropped, then drain
    doReset(1);
    sendByte(8'hA5, 0, 1'b0);
    sendByte(8'h11, 0, 1'b0);
    sendByte(8'h22, 0, 1'b0);
    sendByte(8'h33, 0, 1'b0);
    sendByte(8'h44, 0, 1'b0);
    cmp("bp_overflow", overflow, 1);
    cmp("bp_head", byte_data, 8'h11);
    cmp("bp_head_sof", byte_sof, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    cmp("bp_second", byte_data, 8'h22);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    cmp("bp_drained", byte_valid, 0);
    cmp("bp_overflow_sticky", overflow, 1);
    frame = '{8'h11, 8'h22};
    checkGot("backpressure", frame, 0);

    // Reset in the middle of a frame
    doReset(1);
    sendByte(8'hA5, 0, 1'b1);
    sendByte(8'h11, 0, 1'b1);
    for (int i = 7; i >= 4; i--) applyStimulus(1'b1, 1'((8'h22 >> i) & 1), 1'b1, 1'b1);
    doReset(1);
    cmp("midrst_valid", byte_valid, 0);
    cmp("midrst_locked", locked, 0);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, 1'((8'h22 >> i) & 1), 1'b1, 1'b1);
    sendByte(8'h33, 0, 1'b1);
    sendByte(8'h44, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    cmp("midrst_nobytes", gotQ.size(), 0);

    // Randomized traffic with embedded sync words and occasional reset
    begin
      int pend[$];
      logic [7:0] b;
      doReset(1);
      for (int cyc = 0; cyc < 4000; cyc++) begin
        logic e;
        logic d;
        if (pend.size() == 0) begin
          b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
          for (int i = 7; i >= 0; i--) pend.push_back(int'(b[i]));
        end
        e = ($urandom_range(0, 3) != 0);
        d = e ? 1'(pend[0]) : 1'($urandom_range(0, 1));
        if (e) void'(pend.pop_front());
        if ($urandom_range(0, 499) == 0)
          applyStimulus(1'b0, d, e, 1'b0);
        else
          applyStimulus(1'b1, d, e, 1'($urandom_range(0, 9) < 7));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_frame_deser.md
# serial_frame_deser

Downstream consumer of the serial bit-shift pipeline. It samples the bit stream emerging from the last shift stage and hunts for a sync word. Once locked, it assembles a fixed number of MSB-first bytes into a frame and hands the bytes to the next stage over a valid/ready interface, buffered in a small FIFO. After the frame ends it returns to hunting. It is the first byte-oriented stage after the bit-level delay chain.

## Interface
- `DW`, 8: bits per byte and sync-word width.
- `SYNC`, 8'hA5: sync pattern, MSB first.
- `FRAME_LEN`, 4: data bytes per frame after the sync word; range 1..255.
- `FIFO_DEPTH`, 2: output buffer entries; power of two, at least 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset is synchronous and active-low.
- `din`, in, 1: serial bit from the upstream shift stage.
- `din_en`, in, 1: `din` is valid this cycle.
- `byte_data`, out, DW: head-of-FIFO byte.
- `byte_valid`, out, 1: FIFO non-empty.
- `byte_ready`, in, 1: consumer accepts the head byte this cycle.
- `byte_sof`, out, 1: head byte is the first byte of a frame.
- `byte_eof`, out, 1: head byte is the last byte of a frame.
- `locked`, out, 1: the state is DATA.
- `overflow`, out, 1: sticky; a completed byte was dropped.

## Operation
- States:
  - HUNT: on each `din_en`, shift `din` into the hunt register `{hunt[DW-2:0], din}`. If the new value equals SYNC, go to DATA with the bit count and byte count at 0.
  - DATA: on each `din_en`, shift `din` into the assembly register and increment the bit count.
    - On the DW-th bit, push `{sof = (byte_cnt==0), eof = (byte_cnt==FRAME_LEN-1), byte}`, then clear the bit count and increment the byte count.
    - After the push of the eof byte, go to HUNT and clear the hunt register to 0.
- Sync detection:
  - Bit-overlapping: the sync is checked after every sampled bit, not on byte boundaries.
  - The sync is not searched for while in DATA.
- Bits with `din_en`=0 are ignored; the counters and registers hold.
- FIFO push and pop:
  - Pop happens when `byte_valid && byte_ready`.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
  - If a push occurs while the FIFO is full and there is no pop that cycle: the byte is dropped, `overflow` is set to 1, and the frame and byte counting continue unchanged.
- `overflow` is cleared only by reset.
- `byte_data`, `byte_sof` and `byte_eof` are don't-care when `byte_valid`=0; the bench checks them only when valid.

## Timing
- All outputs at reset are 0. `rst_n`=0 at an edge clears:
  - the state to HUNT;
  - the hunt and assembly registers and all counters;
  - the FIFO to empty;
  - `overflow`.
- Reset mid-frame discards any partial byte and all buffered bytes. There is no flush handshake.
- `locked` rises the cycle after the edge that sampled the last sync bit.
- Byte latency:
  - The last data bit is sampled at edge N. With the FIFO empty, `byte_valid` is 1 from edge N+1.
  - On the same edge, `locked` falls if that byte was the eof byte.
- Back-to-back frames: the bit after the eof byte's last bit is the first bit of the new hunt. The minimum gap between the last data bit and the first new data bit is DW bits.
- Throughput: one byte per DW valid bits. With `byte_ready` held high, the FIFO never exceeds 1 entry.

## Structure
- Shared package holds:
  - the state enum {HUNT, DATA};
  - the FIFO entry struct {sof, eof, data[DW-1:0]};
  - the default SYNC constant.
- Sub-module `sync_fifo`:
  - parameterised width and depth;
  - same `clk`/`rst_n`;
  - push/pop/full/empty;
  - simultaneous push and pop allowed when full.
- The top level contains the FSM, the hunt and assembly registers, the counters, and the overflow logic.

## Test plan
- Reset:
  - Hold `rst_n`=0 for 3 cycles with `din`=1 and `din_en`=1.
  - Required: all outputs 0.
  - Release reset, send 16 bits of 0.
  - Required: `byte_valid` stays 0 and `locked` stays 0.
- Basic frame:
  - `din_en`=1 continuously, `byte_ready`=1. Bits: A5, 11, 22, 33, 44 (MSB first).
  - Required: bytes 11, 22, 33, 44 out in order; `sof` only on 11, `eof` only on 44.
  - Required: 11 becomes valid exactly 1 cycle after its 8th bit; `locked` falls with 44.
- Unaligned sync:
  - Bits: 101, then A5, then 5A 00 FF 81.
  - Required: lock after the A5; output 5A, 00, FF, 81.
- Gaps:
  - Same frame as the basic-frame test, with `din_en` low on every other cycle.
  - Required: identical byte output, at half rate.
- Backpressure:
  - `byte_ready`=0 throughout the basic-frame test.
  - Required: 11 and 22 are held; 33 and 44 are dropped; `overflow`=1 and stays 1.
  - Then raise `byte_ready`. Required: 11 (`sof`), then 22, are drained; `overflow` remains 1.
- Reset mid-frame:
  - Assert `rst_n`=0 for 1 cycle after A5, 11, and 4 bits of 22.
  - Required: FIFO empty and `locked`=0.
  - The remaining stream without a new sync produces no bytes.
